// File: rtl/serializer8_if.sv
// Handshake and serial-output bundle for serializer8.
//   d_valid / d_ready / d : parallel word handshake (master drives d_valid, d)
//   s_out / s_valid / s_last / busy : bit-serial output stream (driven by the serializer)
// The serializer uses the slave modport; the word source uses the master modport.
interface serializer8_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] d;
    logic             s_out;
    logic             s_valid;
    logic             s_last;
    logic             busy;

    modport master (
        output d_valid,
        output d,
        input  d_ready,
        input  s_out,
        input  s_valid,
        input  s_last,
        input  busy
    );

    modport slave (
        input  d_valid,
        input  d,
        output d_ready,
        output s_out,
        output s_valid,
        output s_last,
        output busy
    );
endinterface

// File: rtl/serializer8.sv
// Parallel-in / serial-out transmitter.
// Accepts one WIDTH-bit word on a valid/ready handshake and shifts it out one bit per clock.
// A new word may be accepted during the last-bit cycle so words stream back to back.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus_io  : serializer8_if.slave (d_valid/d_ready/d in, s_out/s_valid/s_last/busy out)
// Parameters:
//   WIDTH     : word width (>= 2)
//   MSB_FIRST : 0 sends d[0] first, 1 sends d[WIDTH-1] first
module serializer8 #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           reset_n,
    serializer8_if.slave   bus_io
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sreg_q, sreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic in_shift;
    logic last_bit;
    logic ready;
    logic accept;

    // Outputs depend on registered state only; d never reaches s_out combinationally.
    always_comb begin
        in_shift = (state_q == StShift);
        last_bit = in_shift && (cnt_q == LastCnt);
        ready    = (state_q == StIdle) || last_bit;
        accept   = bus_io.d_valid && ready;

        bus_io.d_ready = ready;
        bus_io.s_valid = in_shift;
        bus_io.busy    = in_shift;
        bus_io.s_last  = last_bit;
        bus_io.s_out   = 1'b0;
        if (in_shift) begin
            bus_io.s_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sreg_d  = bus_io.d;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!last_bit) begin
                    cnt_d = cnt_q + 1'b1;
                    // Move the next bit toward the output end, zero-filling behind it.
                    if (MSB_FIRST) begin
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                    end
                end else if (accept) begin
                    // Back-to-back: next word loads in the last-bit cycle, no gap.
                    sreg_d = bus_io.d;
                    cnt_d  = '0;
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    sreg_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_serializer8.sv
// Directed bench for serializer8: a vector table for the LSB-first instance plus
// hand-written sequences for reset, MSB-first order and asynchronous abort.
module tb_serializer8;
    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    serializer8_if #(.WIDTH(8)) u_if ();
    serializer8_if #(.WIDTH(8)) m_if ();

    serializer8 #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (u_if.slave)
    );

    serializer8 #(.WIDTH(8), .MSB_FIRST(1'b1)) m_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (m_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector: inputs for one cycle and expected {d_ready, s_valid, s_last, s_out} in that cycle.
    typedef struct packed {
        logic       dv;
        logic [7:0] d;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // {d_ready, s_valid, s_last, s_out, busy}
    function automatic logic [4:0] outs(input bit which);
        if (which)
            return {m_if.d_ready, m_if.s_valid, m_if.s_last, m_if.s_out, m_if.busy};
        return {u_if.d_ready, u_if.s_valid, u_if.s_last, u_if.s_out, u_if.busy};
    endfunction

    task automatic push_idle(input logic dv, input logic [7:0] d);
        vecs.push_back('{dv: dv, d: d, exp: 4'b1000});
    endtask

    task automatic push_bit(input logic dv, input logic [7:0] d, input logic b,
                            input logic last);
        vecs.push_back('{dv: dv, d: d, exp: {last, 1'b1, last, b}});
    endtask

    task automatic drive(input bit which, input logic dv, input logic [7:0] d);
        if (which) begin
            m_if.d_valid = dv;
            m_if.d       = d;
        end else begin
            u_if.d_valid = dv;
            u_if.d       = d;
        end
    endtask

    // Send one word; seq lists the expected serial bits, seq[7] transmitted first.
    task automatic send_word(input bit which, input logic [7:0] word, input logic [7:0] seq,
                             input string name);
        logic [4:0] o;
        @(negedge clk);
        drive(which, 1'b1, word);
        #1 chk({name, "_accept"}, {3'b0, outs(which)}, 8'b0001_0000);
        @(negedge clk);
        drive(which, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1 o = outs(which);
            chk($sformatf("%s_bit%0d", name, k), {3'b0, o},
                {3'b0, (k == 7), 1'b1, (k == 7), seq[7-k], 1'b1});
        end
        @(negedge clk);
        #1 chk({name, "_idle"}, {3'b0, outs(which)}, 8'b0001_0000);
    endtask

    initial begin
        // Reset held with d_valid high: nothing may start.
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 8'hFF);
        drive(1'b1, 1'b1, 8'hFF);
        repeat (3) begin
            @(negedge clk);
            #1 chk("reset_u", {3'b0, outs(1'b0)}, 8'b0001_0000);
            chk("reset_m", {3'b0, outs(1'b1)}, 8'b0001_0000);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        repeat (2) begin
            @(negedge clk);
            #1 chk("post_reset", {3'b0, outs(1'b0)}, 8'b0001_0000);
        end

        // Single word 0xA5, LSB first: 1,0,1,0,0,1,0,1.
        push_idle(1'b1, 8'hA5);
        for (int k = 0; k < 8; k++) push_bit(1'b0, 8'h00, 8'b10100101 >> (7 - k), k == 7);
        push_idle(1'b0, 8'h00);
        // Back-to-back: 0xFF held, 0x00 presented in the last-bit cycle.
        push_idle(1'b1, 8'hFF);
        for (int k = 0; k < 8; k++) push_bit(1'b1, (k == 7) ? 8'h00 : 8'hFF, 1'b1, k == 7);
        for (int k = 0; k < 8; k++) push_bit(1'b0, 8'h00, 1'b0, k == 7);
        push_idle(1'b0, 8'h00);
        // 0x3C with d_valid pulses and changing d during bits 2-6: 0,0,1,1,1,1,0,0.
        push_idle(1'b1, 8'h3C);
        for (int k = 0; k < 8; k++)
            push_bit((k >= 1 && k <= 5) ? logic'(k % 2) : 1'b0, 8'(k * 8'h11 + 8'h81),
                     8'b00111100 >> (7 - k), k == 7);
        push_idle(1'b0, 8'hFF);
        push_idle(1'b0, 8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1'b0, vecs[i].dv, vecs[i].d);
            #1 chk($sformatf("vec%0d", i), {3'b0, outs(1'b0)},
                   {3'b0, vecs[i].exp, vecs[i].exp[2]});
        end
        drive(1'b0, 1'b0, 8'h00);

        // MSB-first order.
        send_word(1'b1, 8'h81, 8'b10000001, "msb81");
        send_word(1'b1, 8'hC0, 8'b11000000, "msbC0");

        // Asynchronous abort during bit 4 of 0xFF.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        #1 chk("abort_pre", {3'b0, outs(1'b0)}, 8'b0000_1011);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("abort_async", {3'b0, outs(1'b0)}, 8'b0001_0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("abort_release", {3'b0, outs(1'b0)}, 8'b0001_0000);
        send_word(1'b0, 8'h5A, 8'b01011010, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
